// File: rtl/fe_redirect_ctrl_pkg.sv
// Shared types for front-end redirect sequencing: FSM state encoding and
// redirect request priority levels.
package fe_redirect_ctrl_pkg;

   typedef enum logic [2:0] {
      BOOT     = 3'd0,
      RUN      = 3'd1,
      FLUSH    = 3'd2,
      REDIRECT = 3'd3,
      WARMUP   = 3'd4
   } fe_redir_state_t;

   typedef logic [1:0] redir_prio_t;

   // Higher value wins; NONE doubles as "nothing pending".
   localparam redir_prio_t PRIO_NONE      = 2'd0;
   localparam redir_prio_t PRIO_JUMP      = 2'd1;
   localparam redir_prio_t PRIO_BRANCH    = 2'd2;
   localparam redir_prio_t PRIO_EXCEPTION = 2'd3;

endpackage

// File: rtl/fe_redirect_ctrl_if.sv
// Signal bundle between back-end resolution, the redirect controller and the
// front-end top. master = controller side, slave = surrounding logic.
interface fe_redirect_ctrl_if #(
   parameter int PC_WIDTH  = 32,
   parameter int CNT_WIDTH = 16
);
   logic                 exception_req;
   logic [PC_WIDTH-1:0]  exception_target;
   logic                 branch_req;
   logic [PC_WIDTH-1:0]  branch_target;
   logic                 jump_req;
   logic [PC_WIDTH-1:0]  jump_target;
   logic                 backend_stall;
   logic                 fifo_if_id_empty;
   logic                 fifo_id_mp_empty;
   logic                 fifo_mp_rn_empty;

   logic                 flush;
   logic                 redirect;
   logic [PC_WIDTH-1:0]  pc_override;
   logic                 if_en;
   logic                 id_en;
   logic                 stall;
   logic                 busy;
   logic [CNT_WIDTH-1:0] redirect_count;

   modport master (
      input  exception_req, exception_target,
      input  branch_req, branch_target,
      input  jump_req, jump_target,
      input  backend_stall,
      input  fifo_if_id_empty, fifo_id_mp_empty, fifo_mp_rn_empty,
      output flush, redirect, pc_override,
      output if_en, id_en, stall, busy, redirect_count
   );

   modport slave (
      output exception_req, exception_target,
      output branch_req, branch_target,
      output jump_req, jump_target,
      output backend_stall,
      output fifo_if_id_empty, fifo_id_mp_empty, fifo_mp_rn_empty,
      input  flush, redirect, pc_override,
      input  if_en, id_en, stall, busy, redirect_count
   );

endinterface

// File: rtl/fe_redirect_ctrl_arbiter.sv
// Fixed-priority redirect picker: exception > branch > jump. Purely
// combinational so the back end can reuse it for its own ordering.
module redir_arbiter
   import fe_redirect_ctrl_pkg::*;
#(
   parameter int PC_WIDTH = 32
) (
   input  logic                exc_req,
   input  logic [PC_WIDTH-1:0] exc_target,
   input  logic                br_req,
   input  logic [PC_WIDTH-1:0] br_target,
   input  logic                jmp_req,
   input  logic [PC_WIDTH-1:0] jmp_target,
   output logic                valid,
   output redir_prio_t         prio,
   output logic [PC_WIDTH-1:0] target
);

   always_comb begin
      valid  = exc_req | br_req | jmp_req;
      prio   = PRIO_NONE;
      target = '0;
      if (exc_req) begin
         prio   = PRIO_EXCEPTION;
         target = exc_target;
      end else if (br_req) begin
         prio   = PRIO_BRANCH;
         target = br_target;
      end else if (jmp_req) begin
         prio   = PRIO_JUMP;
         target = jmp_target;
      end
   end

endmodule

// File: rtl/fe_redirect_ctrl.sv
// Front-end redirect sequencer: flush the decode FIFOs, wait for drain, drive a
// one-cycle PC override, then bring fetch and decode back up in order.
//
// state    | meaning
// ---------+------------------------------------------------------------
// BOOT     | post-reset settle, fetch held off, requests ignored
// RUN      | normal operation, any request starts a flush
// FLUSH    | flush held for a minimum time and until all FIFOs drain
// REDIRECT | single cycle: pc_override loaded into fetch
// WARMUP   | single cycle: fetch running, decode still held
module fe_redirect_ctrl
   import fe_redirect_ctrl_pkg::*;
#(
   parameter int PC_WIDTH     = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int BOOT_CYCLES  = 4,
   parameter int CNT_WIDTH    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   fe_redirect_ctrl_if.master fe
);

   localparam int TMR_MAX = (BOOT_CYCLES > FLUSH_CYCLES) ? BOOT_CYCLES : FLUSH_CYCLES;
   localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);
   localparam logic [TMR_W-1:0] TMR_BOOT  = TMR_W'(BOOT_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_FLUSH = TMR_W'(FLUSH_CYCLES - 1);

   fe_redir_state_t      state_q, state_d;
   logic [TMR_W-1:0]     tmr_q, tmr_d;
   logic [PC_WIDTH-1:0]  pend_pc_q, pend_pc_d;
   redir_prio_t          pend_prio_q, pend_prio_d;

   logic                 flush_q, flush_d;
   logic                 redirect_q, redirect_d;
   logic [PC_WIDTH-1:0]  pc_override_q, pc_override_d;
   logic                 if_en_q, if_en_d;
   logic                 id_en_q, id_en_d;
   logic                 stall_q, stall_d;
   logic                 busy_q, busy_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;

   logic                 arb_valid;
   redir_prio_t          arb_prio;
   logic [PC_WIDTH-1:0]  arb_target;
   logic                 fifos_empty;

   redir_arbiter #(.PC_WIDTH(PC_WIDTH)) u_arb (
      .exc_req    (fe.exception_req),
      .exc_target (fe.exception_target),
      .br_req     (fe.branch_req),
      .br_target  (fe.branch_target),
      .jmp_req    (fe.jump_req),
      .jmp_target (fe.jump_target),
      .valid      (arb_valid),
      .prio       (arb_prio),
      .target     (arb_target)
   );

   assign fifos_empty = fe.fifo_if_id_empty & fe.fifo_id_mp_empty & fe.fifo_mp_rn_empty;

   always_comb begin
      state_d     = state_q;
      tmr_d       = tmr_q;
      pend_pc_d   = pend_pc_q;
      pend_prio_d = pend_prio_q;
      case (state_q)
         BOOT: begin
            if (tmr_q == '0) state_d = RUN;
            else             tmr_d   = tmr_q - 1'b1;
         end
         // A request right after a redirect starts afresh; the finished
         // redirect's priority no longer matters.
         RUN, REDIRECT, WARMUP: begin
            if (arb_valid) begin
               state_d     = FLUSH;
               tmr_d       = TMR_FLUSH;
               pend_pc_d   = arb_target;
               pend_prio_d = arb_prio;
            end else if (state_q == REDIRECT) begin
               state_d = WARMUP;
            end else if (state_q == WARMUP) begin
               state_d     = RUN;
               pend_prio_d = PRIO_NONE;
            end
         end
         FLUSH: begin
            if (arb_valid && (arb_prio >= pend_prio_q)) begin
               tmr_d       = TMR_FLUSH;
               pend_pc_d   = arb_target;
               pend_prio_d = arb_prio;
            end else if ((tmr_q == '0) && fifos_empty) begin
               state_d = REDIRECT;
            end else if (tmr_q != '0) begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   // Outputs are decoded from the next state so they register alongside it.
   always_comb begin
      flush_d       = 1'b0;
      redirect_d    = 1'b0;
      if_en_d       = 1'b0;
      id_en_d       = 1'b0;
      stall_d       = 1'b1;
      busy_d        = 1'b1;
      pc_override_d = pc_override_q;
      count_d       = count_q;
      case (state_d)
         RUN: begin
            if_en_d = 1'b1;
            id_en_d = 1'b1;
            stall_d = fe.backend_stall;
            busy_d  = 1'b0;
         end
         FLUSH: flush_d = 1'b1;
         REDIRECT: begin
            redirect_d    = 1'b1;
            if_en_d       = 1'b1;
            stall_d       = 1'b0;
            pc_override_d = pend_pc_d;
            if (count_q != '1) count_d = count_q + 1'b1;
         end
         WARMUP: begin
            if_en_d = 1'b1;
            stall_d = fe.backend_stall;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= BOOT;
         tmr_q         <= TMR_BOOT;
         pend_pc_q     <= '0;
         pend_prio_q   <= PRIO_NONE;
         flush_q       <= 1'b0;
         redirect_q    <= 1'b0;
         pc_override_q <= '0;
         if_en_q       <= 1'b0;
         id_en_q       <= 1'b0;
         stall_q       <= 1'b1;
         busy_q        <= 1'b1;
         count_q       <= '0;
      end else begin
         state_q       <= state_d;
         tmr_q         <= tmr_d;
         pend_pc_q     <= pend_pc_d;
         pend_prio_q   <= pend_prio_d;
         flush_q       <= flush_d;
         redirect_q    <= redirect_d;
         pc_override_q <= pc_override_d;
         if_en_q       <= if_en_d;
         id_en_q       <= id_en_d;
         stall_q       <= stall_d;
         busy_q        <= busy_d;
         count_q       <= count_d;
      end
   end

   assign fe.flush          = flush_q;
   assign fe.redirect       = redirect_q;
   assign fe.pc_override    = pc_override_q;
   assign fe.if_en          = if_en_q;
   assign fe.id_en          = id_en_q;
   assign fe.stall          = stall_q;
   assign fe.busy           = busy_q;
   assign fe.redirect_count = count_q;

endmodule

// File: tb/tb_fe_redirect_ctrl.sv
// Bench for fe_redirect_ctrl: directed redirect scenarios with a scoreboard of
// expected (target, count, cycle) checked by an independent redirect monitor.
module tb_fe_redirect_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   fe_redirect_ctrl_if #(.PC_WIDTH(32), .CNT_WIDTH(16)) if_a ();
   fe_redirect_ctrl_if #(.PC_WIDTH(32), .CNT_WIDTH(2))  if_b ();

   fe_redirect_ctrl #(.PC_WIDTH(32), .FLUSH_CYCLES(2), .BOOT_CYCLES(4), .CNT_WIDTH(16))
      dut_a (.clk(clk), .rst_n(rst_n), .fe(if_a));
   fe_redirect_ctrl #(.PC_WIDTH(32), .FLUSH_CYCLES(2), .BOOT_CYCLES(4), .CNT_WIDTH(2))
      dut_b (.clk(clk), .rst_n(rst_n), .fe(if_b));

   assign if_b.exception_req    = if_a.exception_req;
   assign if_b.exception_target = if_a.exception_target;
   assign if_b.branch_req       = if_a.branch_req;
   assign if_b.branch_target    = if_a.branch_target;
   assign if_b.jump_req         = if_a.jump_req;
   assign if_b.jump_target      = if_a.jump_target;
   assign if_b.backend_stall    = if_a.backend_stall;
   assign if_b.fifo_if_id_empty = if_a.fifo_if_id_empty;
   assign if_b.fifo_id_mp_empty = if_a.fifo_id_mp_empty;
   assign if_b.fifo_mp_rn_empty = if_a.fifo_mp_rn_empty;

   typedef struct {
      logic [31:0] pc;
      int          cnt;
      int          at;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   n_model = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_redirect(input logic [31:0] pc, input int at);
      exp_t e;
      n_model++;
      e.pc  = pc;
      e.cnt = n_model;
      e.at  = at;
      sb.push_back(e);
   endtask

   // One-cycle request pulse; returns the cycle in which it was presented.
   task automatic issue(input logic e, input logic b, input logic j,
                        input logic [31:0] te, input logic [31:0] tbr,
                        input logic [31:0] tj, output int rc);
      if_a.exception_req    = e;
      if_a.exception_target = te;
      if_a.branch_req       = b;
      if_a.branch_target    = tbr;
      if_a.jump_req         = j;
      if_a.jump_target      = tj;
      rc = cyc;
      sync();
      if_a.exception_req = 1'b0;
      if_a.branch_req    = 1'b0;
      if_a.jump_req      = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (if_a.busy && k < 60);
      chk("idle_timeout", 32'(if_a.busy), 32'd0);
      sync();
   endtask

   // Redirect monitor: target and timing on the redirect cycle, counters one
   // cycle later (both DUT instances; the 2-bit one saturates at 3).
   logic cnt_chk = 1'b0;
   int   cnt_exp = 0;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (cnt_chk) begin
            chk("redirect_count", 32'(if_a.redirect_count), 32'(cnt_exp));
            chk("redirect_count_sat", 32'(if_b.redirect_count), 32'((cnt_exp > 3) ? 3 : cnt_exp));
            cnt_chk = 1'b0;
         end
         if (rst_n && if_a.redirect) begin
            n_vec++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_redirect: got pc %0h at cycle %0d, expected none",
                        if_a.pc_override, cyc);
            end else begin
               e = sb.pop_front();
               chk("pc_override", if_a.pc_override, e.pc);
               chk("redirect_cycle", 32'(cyc), 32'(e.at));
               chk("pc_override_sat", if_b.pc_override, e.pc);
               chk("id_en_in_redirect", 32'(if_a.id_en), 32'd0);
               cnt_chk = 1'b1;
               cnt_exp = e.cnt;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int rc;
      if_a.exception_req    = 1'b0;
      if_a.exception_target = '0;
      if_a.branch_req       = 1'b0;
      if_a.branch_target    = '0;
      if_a.jump_req         = 1'b0;
      if_a.jump_target      = '0;
      if_a.backend_stall    = 1'b0;
      if_a.fifo_if_id_empty = 1'b1;
      if_a.fifo_id_mp_empty = 1'b1;
      if_a.fifo_mp_rn_empty = 1'b1;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;

      // Reset values, with a request held to show reset wins.
      if_a.branch_req = 1'b1;
      repeat (2) sync();
      chk("rst_flush",    32'(if_a.flush),    32'd0);
      chk("rst_redirect", 32'(if_a.redirect), 32'd0);
      chk("rst_if_en",    32'(if_a.if_en),    32'd0);
      chk("rst_id_en",    32'(if_a.id_en),    32'd0);
      chk("rst_stall",    32'(if_a.stall),    32'd1);
      chk("rst_busy",     32'(if_a.busy),     32'd1);
      chk("rst_pc",       if_a.pc_override,   32'd0);
      chk("rst_count",    32'(if_a.redirect_count), 32'd0);
      if_a.branch_req = 1'b0;

      // BOOT holds fetch off for 4 cycles after release.
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("boot_if_en", 32'(if_a.if_en), 32'd0);
         chk("boot_stall", 32'(if_a.stall), 32'd1);
      end
      @(negedge clk);
      chk("run_if_en", 32'(if_a.if_en), 32'd1);
      chk("run_id_en", 32'(if_a.id_en), 32'd1);
      chk("run_busy",  32'(if_a.busy),  32'd0);
      chk("run_stall", 32'(if_a.stall), 32'd0);
      chk("run_count", 32'(if_a.redirect_count), 32'd0);
      sync();

      // Branch, FIFOs empty: flush 2 cycles, redirect on the 3rd.
      issue(1'b0, 1'b1, 1'b0, 32'h0, 32'h100, 32'h0, rc);
      expect_redirect(32'h100, rc + 3);
      @(negedge clk);
      chk("flush_c1", 32'(if_a.flush), 32'd1);
      chk("flush_c1_if_en", 32'(if_a.if_en), 32'd0);
      @(negedge clk);
      chk("flush_c2", 32'(if_a.flush), 32'd1);
      @(negedge clk);
      chk("flush_c3", 32'(if_a.flush), 32'd0);
      chk("redirect_if_en", 32'(if_a.if_en), 32'd1);
      @(negedge clk);
      chk("warmup_id_en", 32'(if_a.id_en), 32'd0);
      chk("warmup_busy",  32'(if_a.busy),  32'd1);
      wait_idle();

      // Exception and jump together: exception wins.
      issue(1'b1, 1'b0, 1'b1, 32'h80, 32'h0, 32'h200, rc);
      expect_redirect(32'h80, rc + 3);
      wait_idle();

      // Exception preempts a pending branch; a later jump is dropped.
      issue(1'b0, 1'b1, 1'b0, 32'h0, 32'h100, 32'h0, rc);
      issue(1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 32'h0, rc);
      expect_redirect(32'h80, rc + 3);
      issue(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h300, rc);
      wait_idle();

      // MP/RN FIFO stays full 5 cycles into the flush.
      if_a.fifo_mp_rn_empty = 1'b0;
      issue(1'b0, 1'b1, 1'b0, 32'h0, 32'h400, 32'h0, rc);
      expect_redirect(32'h400, rc + 7);
      repeat (5) sync();
      if_a.fifo_mp_rn_empty = 1'b1;
      @(negedge clk);
      chk("flush_held_not_empty", 32'(if_a.flush), 32'd1);
      wait_idle();

      // backend_stall passes through in RUN but never blocks a redirect.
      if_a.backend_stall = 1'b1;
      sync();
      @(negedge clk);
      chk("run_stall_pass", 32'(if_a.stall), 32'd1);
      sync();
      issue(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h200, rc);
      expect_redirect(32'h200, rc + 3);
      wait_idle();
      if_a.backend_stall = 1'b0;
      sync();

      // Exception redirect, then a jump during WARMUP still starts a new flush.
      issue(1'b1, 1'b0, 1'b0, 32'h700, 32'h0, 32'h0, rc);
      expect_redirect(32'h700, rc + 3);
      repeat (3) sync();
      issue(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h500, rc);
      expect_redirect(32'h500, rc + 3);
      wait_idle();

      // Asynchronous reset in the middle of FLUSH.
      issue(1'b0, 1'b1, 1'b0, 32'h0, 32'h900, 32'h0, rc);
      chk("pre_reset_flush", 32'(if_a.flush), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_flush", 32'(if_a.flush), 32'd0);
      chk("async_rst_stall", 32'(if_a.stall), 32'd1);
      chk("async_rst_busy",  32'(if_a.busy),  32'd1);
      chk("async_rst_if_en", 32'(if_a.if_en), 32'd0);
      chk("async_rst_pc",    if_a.pc_override, 32'd0);
      chk("async_rst_count", 32'(if_a.redirect_count), 32'd0);
      chk("async_rst_count_sat", 32'(if_b.redirect_count), 32'd0);
      sync();
      rst_n = 1'b1;
      wait_idle();
      @(negedge clk);
      chk("post_rst_redirect", 32'(if_a.redirect), 32'd0);
      chk("post_rst_count", 32'(if_a.redirect_count), 32'd0);

      repeat (3) sync();
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
